// File: rtl/rr_grant_sequencer.sv
// Round-robin owner of a shared one-hot select resource: one grant at a time,
// held until done/withdrawal/watchdog, followed by a single break-before-make gap.
module rr_grant_sequencer #(
  parameter int NREQ     = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    done,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic [NREQ-1:0]         gnt,
  output logic                    gnt_valid,
  output logic                    timeout
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [7:0]    hold_cnt;
  logic [IW-1:0] pick;
  logic          wd_hit;
  logic          owner_req;
  logic          rel;

  // First set request at or after ptr; scanning downward leaves the nearest one.
  always_comb begin
    pick = ptr;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[ptr + IW'(i)]) pick = ptr + IW'(i);
    end
  end

  assign wd_hit    = (hold_cnt == 8'(HOLD_MAX-1));
  assign owner_req = req[gnt_idx];
  assign rel       = done | ~owner_req | wd_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= pick;
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IW'(1);
            // A watchdog expiry that coincides with a normal release is not a timeout.
            timeout   <= wd_hit & ~done & owner_req;
            state     <= GAP;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
